// File: rtl/dipsw_mode_ctrl.sv
// rtl/dipsw_mode_ctrl.sv - dip-switch mode word capture with settle, stability window and ack handshake
module dipsw_mode_ctrl #(
  parameter logic [20:0] P_INIT = 21'h142440,
  parameter logic [16:0] P_HOLD = 17'h101D0
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST,
  input  logic [7:0] FILT_IN,
  input  logic       MODE_ACK,
  input  logic       CHG_CLR,
  output logic [7:0] MODE_OUT,
  output logic       MODE_VALID,
  output logic       MODE_CHG,
  output logic       MODE_REQ,
  output logic       CHG_FLAG
);

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_HOLD     = 3'd2;
  localparam logic [2:0] ST_UPDATE   = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;

  localparam logic [20:0] INIT_LAST = P_INIT - 21'd1;
  localparam logic [20:0] HOLD_LAST = {4'd0, P_HOLD} - 21'd1;

  logic [2:0]  state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [7:0]  r_in_q;
  logic [7:0]  cand_q, cand_d;
  logic [7:0]  mode_q, mode_d;
  logic        valid_q, valid_d;
  logic        chg_q, chg_d;
  logic        req_q, req_d;
  logic        flag_q, flag_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    req_d   = req_q;
    flag_d  = CHG_CLR ? 1'b0 : flag_q;

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          mode_d  = r_in_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      ST_IDLE: begin
        if (r_in_q != mode_q) begin
          cand_d  = r_in_q;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Returning to the current word is a glitch; any other change restarts the window.
        if (r_in_q == mode_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (r_in_q != cand_q) begin
          cand_d = r_in_q;
          cnt_d  = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      ST_UPDATE: begin
        mode_d  = cand_q;
        chg_d   = 1'b1;
        req_d   = 1'b1;
        flag_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (MODE_ACK) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      r_in_q  <= '0;
      cand_q  <= '0;
      mode_q  <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      req_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_in_q  <= FILT_IN;
      cand_q  <= cand_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      req_q   <= req_d;
      flag_q  <= flag_d;
    end
  end

  assign MODE_OUT   = mode_q;
  assign MODE_VALID = valid_q;
  assign MODE_CHG   = chg_q;
  assign MODE_REQ   = req_q;
  assign CHG_FLAG   = flag_q;

endmodule

// File: doc/dipsw_mode_ctrl.md
DIPSW_MODE_CTRL -- requirements
Module: dipsw_mode_ctrl

Interface
REQ-001 The block SHALL provide parameter P_INIT, default 21'h142440 (1,320,000 cycles, 20 ms at 66 MHz), as the power-up settle time before the first mode capture.
REQ-002 The block SHALL provide parameter P_HOLD, default 17'h101D0 (66,000 cycles, 1 ms), as the cross-bit stability window for a new mode word.
REQ-003 SYS_CLK  in  1  system clock, 66 MHz; every register is clocked on its rising edge.
REQ-004 SYS_RST  in  1  synchronous reset, active-high.
REQ-005 FILT_IN  in  8  dip-switch bits from eight per-bit 10 ms chattering filters, already in the SYS_CLK domain.
REQ-006 MODE_ACK  in  1  downstream acknowledge of MODE_REQ.
REQ-007 CHG_CLR  in  1  clears CHG_FLAG.
REQ-008 MODE_OUT  out  8  current accepted mode word.
REQ-009 MODE_VALID  out  1  high once the first mode word has been captured.
REQ-010 MODE_CHG  out  1  one-cycle pulse on every accepted mode change after init.
REQ-011 MODE_REQ  out  1  update request, held until acknowledged.
REQ-012 CHG_FLAG  out  1  sticky change indicator.

Function
REQ-013 The block SHALL register FILT_IN into r_in on every cycle, and all decisions SHALL use r_in.
REQ-014 The FSM SHALL have exactly five states: INIT, IDLE, HOLD, UPDATE and WAIT_ACK.
REQ-015 Counter cnt SHALL be 21 bits, unsigned, with no wrap; it is cleared on every state entry.
REQ-016 INIT: cnt SHALL increment each cycle; when cnt==P_INIT-1, the next edge SHALL load MODE_OUT<=r_in, set MODE_VALID=1, and go to IDLE, with no MODE_CHG, MODE_REQ or CHG_FLAG.
REQ-017 IDLE: if r_in!=MODE_OUT, the block SHALL set cand<=r_in, cnt<=0, and go to HOLD; otherwise it SHALL stay in IDLE.
REQ-018 HOLD: priorities SHALL apply in this order:
- (a) r_in==MODE_OUT -> go to IDLE, no update (glitch rejected).
- (b) r_in!=cand -> set cand<=r_in, cnt<=0, stay in HOLD (window restarts).
- (c) cnt==P_HOLD-1 -> go to UPDATE.
- (d) otherwise -> cnt+1.
REQ-019 UPDATE SHALL last one cycle; on exit the block SHALL set MODE_OUT<=cand, MODE_CHG=1 for one cycle, MODE_REQ=1, CHG_FLAG=1, and go to WAIT_ACK.
REQ-020 Latency SHALL be as follows: a new FILT_IN value first sampled into r_in at edge E0 and held stable SHALL appear on MODE_OUT/MODE_CHG/MODE_REQ at edge E0+P_HOLD+2.
REQ-021 WAIT_ACK: MODE_REQ SHALL stay high until MODE_ACK is sampled high; that edge SHALL clear MODE_REQ and return to IDLE.
REQ-022 If MODE_ACK is already high on the cycle MODE_REQ rises, the handshake SHALL complete on the following edge, so MODE_REQ is high for exactly one cycle.
REQ-023 FILT_IN changes during WAIT_ACK SHALL NOT be tracked; IDLE re-evaluates r_in against MODE_OUT after the handshake.
REQ-024 MODE_ACK outside WAIT_ACK SHALL be ignored.
REQ-025 CHG_FLAG SHALL clear on CHG_CLR=1; if CHG_CLR=1 coincides with the set in REQ-019, the set SHALL win.
REQ-026 MODE_OUT SHALL change only in the INIT load and on UPDATE exit.

Reset
REQ-027 SYS_RST=1 SHALL force the following on the next edge:
- state=INIT, cnt=0, r_in=0, cand=0.
- MODE_OUT=8'h00, MODE_VALID=0, MODE_CHG=0, MODE_REQ=0, CHG_FLAG=0.
REQ-028 Reset asserted in any state, including WAIT_ACK with MODE_REQ high, SHALL abort without completing the handshake.
REQ-029 After reset release, MODE_VALID SHALL rise at the P_INIT-th rising edge following the last edge that sampled SYS_RST high.

Verification (P_INIT=16, P_HOLD=8)
REQ-030 Reset release with FILT_IN=8'h5A: MODE_VALID and MODE_OUT=8'h5A at edge 16; MODE_CHG, MODE_REQ and CHG_FLAG stay 0.
REQ-031 From IDLE with MODE_OUT=8'h5A, FILT_IN->8'h3C held: MODE_OUT=8'h3C, MODE_CHG pulses once and MODE_REQ rises at E0+10; MODE_ACK pulse drops MODE_REQ on the next edge.
REQ-032 FILT_IN 8'h5A->8'h3C for 4 cycles, then back to 8'h5A: return to IDLE, MODE_OUT stays 8'h5A, no MODE_CHG.
REQ-033 FILT_IN 8'h5A->8'h58 for 5 cycles, then 8'h18 held: MODE_OUT=8'h18 at 10 edges after 8'h18 is first sampled; 8'h58 never appears on MODE_OUT.
REQ-034 CHG_CLR=1 held across the UPDATE exit edge: CHG_FLAG=1; CHG_CLR still high on the next edge -> CHG_FLAG=0.
REQ-035 SYS_RST pulsed while MODE_REQ=1 in WAIT_ACK: all outputs 0, state INIT, MODE_VALID reasserts 16 edges later.
